data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory port. Accepts word load/store requests on the address, write-data and write-enable signals driven by the core.
- Serves requests from an internal word RAM and a small memory-mapped I/O region: an LED output register and a free-running timer.
- Each access completes after a configurable number of wait states with a registered ready pulse. This lets the core (or a future multicycle core) stall on memory.

Parameters:
DEPTH, 64, RAM size in 32-bit words (power of two, 4..1024)
WAIT_STATES, 1, extra cycles per access (0..15)
IO_BASE, 32'h8000_0000, base address of I/O region

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset (reset=0 resets)
req  input  1  access request, held by initiator until ready
we  input  1  1=store, 0=load (core MemWrite)
addr  input  32  byte address (core ALUResult)
wdata  input  32  store data (core WriteData)
rdata  output  32  load data, valid when ready=1
ready  output  1  one-cycle completion pulse
err  output  1  with ready: access rejected
io_out  output  32  LED register contents

Behaviour:
- Reset (reset=0, async): state IDLE; ready=0, err=0, rdata=0, io_out=0, timer=0, wait counter=0. RAM contents are not reset.
- Reset mid-access: the access is abandoned, no write occurs, and no ready is produced.
- Address map (addr[1:0] must be 00):
  - RAM at 0..DEPTH*4-1, index addr[log2(DEPTH)+1:2].
  - IO_BASE+0: LED register, read/write.
  - IO_BASE+4: TIMER, read; any write clears it.
  - Everything else is unmapped.
- FSM states IDLE, WAIT, RESP.
  - IDLE: on an edge with req=1, latch addr/we/wdata and load the counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else perform the access at the next edge.
  - WAIT: decrement the counter each edge. The access is performed at the edge where the counter reaches 0.
  - Access edge: registers rdata/err, sets ready=1, enters RESP.
  - RESP: ready=1 for exactly one cycle. The next edge returns to IDLE unconditionally, and req is ignored on that edge.
- Latency: ready is high in the cycle following edge (acceptance edge + WAIT_STATES + 1). For WAIT_STATES=0, ready is high in the second cycle after the acceptance edge.
- Throughput: one access per WAIT_STATES+3 cycles.
- Initiator rules:
  - req/addr/we/wdata stay stable from acceptance through the ready cycle. The responder uses latched copies, so changes after acceptance are ignored.
  - A new request may be raised in the cycle after ready.
- Store commit happens at the access edge:
  - RAM word written; or io_out<=wdata; or timer<=0.
  - rdata<=0 on a store.
- Load: rdata<=selected word at the access edge.
  - TIMER read returns the timer value before that edge's increment.
- Timer:
  - Increments by 1 every edge, wrapping 32'hFFFF_FFFF→0.
  - A write forces 0 at the commit edge, so it reads 1 at the next edge.
- Errors (misaligned or unmapped):
  - ready with err=1, rdata=0.
  - No state is modified (RAM, io_out and timer are unaffected; the timer keeps counting).
- err=0 whenever ready=0.
- rdata holds its value between responses.

Test Plan:
- Store/load round trip: WAIT_STATES=1. Store 32'hDEADBEEF to 0x10, then load 0x10 → ready 3 cycles after each acceptance edge, rdata=32'hDEADBEEF, err=0. Load of 0x14 returns the RAM's pre-existing content (not reset).
- Zero wait states: WAIT_STATES=0, back-to-back loads with req raised the cycle after ready → one ready every 3 cycles, no request lost or duplicated.
- LED register: store 32'h0000_00A5 to 0x8000_0000 → io_out=32'hA5 from the cycle after the commit edge; load returns 32'hA5.
- Timer clear/read: store to 0x8000_0004, then load it as soon as allowed → value equals the number of edges between the two commit edges. Preload 32'hFFFF_FFFE via force → wraps to 0 after 2 edges.
- Errors: store to 0x12 (misaligned) and to 0x4000_0000 (unmapped) → ready with err=1, rdata=0; a subsequent load of 0x10 shows unchanged contents.
- Reset mid-access: WAIT_STATES=3, assert reset=0 during WAIT of a store to 0x20 → ready never pulses, word 0x20 unchanged, outputs reset immediately (asynchronously), FSM in IDLE after release.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Data-memory port between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus LED/timer I/O, with configurable wait states
// and a registered one-cycle ready pulse per access.
module data_mem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] IO_BASE     = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  output logic [31:0]           io_out
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [3:0]  WS_L = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;
  logic [31:0]   timer_r;
  logic [31:0]   io_r;
  logic          ready_r;
  logic          err_r;
  logic [31:0]   mem_r [DEPTH];

  logic          ram_hit_s;
  logic          led_hit_s;
  logic          tmr_hit_s;
  logic          acc_s;
  logic          mem_we_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   rd_s;

  // Decode the latched address and select load data.
  always_comb begin
    ram_hit_s = 1'b0;
    led_hit_s = 1'b0;
    tmr_hit_s = 1'b0;
    rd_s      = 32'd0;
    ram_idx_s = addr_r[AW+1:2];
    if (addr_r[1:0] == 2'b00) begin
      ram_hit_s = (addr_r[31:AW+2] == {(30-AW){1'b0}});
      led_hit_s = (addr_r == IO_BASE);
      tmr_hit_s = (addr_r == (IO_BASE + 32'd4));
    end else begin
      ram_hit_s = 1'b0;
    end
    if (ram_hit_s) begin
      rd_s = mem_r[ram_idx_s];
    end else if (led_hit_s) begin
      rd_s = io_r;
    end else if (tmr_hit_s) begin
      rd_s = timer_r;
    end else begin
      rd_s = 32'd0;
    end
    acc_s    = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    mem_we_s = acc_s && we_r && ram_hit_s;
  end

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[ram_idx_s] <= wdata_r;
    end
  end

  // Access FSM, free-running timer and registered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      timer_r <= 32'd0;
      io_r    <= 32'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      timer_r <= timer_r + 32'd1;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            addr_r  <= bus.addr;
            we_r    <= bus.we;
            wdata_r <= bus.wdata;
            cnt_r   <= WS_L;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            ready_r <= 1'b1;
            state_r <= ST_RESP;
            if (!(ram_hit_s || led_hit_s || tmr_hit_s)) begin
              err_r   <= 1'b1;
              rdata_r <= 32'd0;
            end else if (we_r) begin
              rdata_r <= 32'd0;
              if (led_hit_s) begin
                io_r <= wdata_r;
              end
              // Clearing overrides this edge's increment.
              if (tmr_hit_s) begin
                timer_r <= 32'd0;
              end
            end else begin
              rdata_r <= rd_s;
            end
          end
        end
        ST_RESP: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign io_out    = io_r;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (0, 1 and 3 wait states) driven by one shared initiator.
module tb_data_mem_responder;
  localparam logic [31:0] IO = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  sel = 2'd1;
  logic [31:0] io0, io1, io3;
  logic        rdy_s, err_s;
  logic [31:0] rdata_s, io_s;
  int          cyc = 0;
  int          rdy_cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();
  data_mem_responder_if bus3();

  assign bus0.req = req && (sel == 2'd0);
  assign bus1.req = req && (sel == 2'd1);
  assign bus3.req = req && (sel == 2'd2);
  assign bus0.we = we;     assign bus1.we = we;     assign bus3.we = we;
  assign bus0.addr = addr; assign bus1.addr = addr; assign bus3.addr = addr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata; assign bus3.wdata = wdata;

  data_mem_responder #(.DEPTH(64), .WAIT_STATES(0), .IO_BASE(IO)) u0 (.clk(clk), .reset(reset), .bus(bus0), .io_out(io0));
  data_mem_responder #(.DEPTH(64), .WAIT_STATES(1), .IO_BASE(IO)) u1 (.clk(clk), .reset(reset), .bus(bus1), .io_out(io1));
  data_mem_responder #(.DEPTH(64), .WAIT_STATES(3), .IO_BASE(IO)) u3 (.clk(clk), .reset(reset), .bus(bus3), .io_out(io3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (sel)
      2'd0:    begin rdy_s = bus0.ready; err_s = bus0.err; rdata_s = bus0.rdata; io_s = io0; end
      2'd1:    begin rdy_s = bus1.ready; err_s = bus1.err; rdata_s = bus1.rdata; io_s = io1; end
      default: begin rdy_s = bus3.ready; err_s = bus3.err; rdata_s = bus3.rdata; io_s = io3; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access; call just after a posedge, returns just after the edge ending the ready cycle.
  task automatic do_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int n);
    we = w; addr = a; wdata = d; req = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy_s && n < 40);
    if (!rdy_s) check_eq("ready_timeout", {31'd0, rdy_s}, 32'd1);
    rd = rdata_s; e = err_s; rdy_cyc = cyc;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          n, pulses, prev_cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, rdy_s}, 32'd0);
    check_eq("rst_err", {31'd0, err_s}, 32'd0);
    check_eq("rst_rdata", rdata_s, 32'd0);
    check_eq("rst_io", io_s, 32'd0);
    check_eq("rst_timer", u1.timer_r, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // One wait state: round trip, boundary word, LED.
    sel = 2'd1;
    do_acc(1'b1, 32'h10, 32'hDEAD_BEEF, rd, e, n);
    check_eq("st10_lat", 32'(n), 32'd4);
    check_eq("st10_err", {31'd0, e}, 32'd0);
    check_eq("st10_rd", rd, 32'd0);
    do_acc(1'b0, 32'h10, 32'd0, rd, e, n);
    check_eq("ld10_lat", 32'(n), 32'd4);
    check_eq("ld10_rd", rd, 32'hDEAD_BEEF);
    check_eq("ld10_err", {31'd0, e}, 32'd0);
    check_eq("idle_err", {31'd0, err_s}, 32'd0);
    do_acc(1'b1, 32'h0, 32'h1111_1111, rd, e, n);
    do_acc(1'b1, 32'hFC, 32'h5A5A_5A5A, rd, e, n);
    do_acc(1'b0, 32'hFC, 32'd0, rd, e, n);
    check_eq("ldFC_rd", rd, 32'h5A5A_5A5A);
    do_acc(1'b1, IO, 32'h0000_00A5, rd, e, n);
    check_eq("led_io", io_s, 32'h0000_00A5);
    do_acc(1'b0, IO, 32'd0, rd, e, n);
    check_eq("led_rd", rd, 32'h0000_00A5);

    // Rejected accesses leave all state alone.
    do_acc(1'b1, 32'h12, 32'hBAD0_0012, rd, e, n);
    check_eq("mis_err", {31'd0, e}, 32'd1);
    check_eq("mis_rd", rd, 32'd0);
    do_acc(1'b1, 32'h4000_0000, 32'hBAD0_4000, rd, e, n);
    check_eq("unm_err", {31'd0, e}, 32'd1);
    check_eq("unm_rd", rd, 32'd0);
    do_acc(1'b1, 32'h100, 32'hBAD0_0100, rd, e, n);
    check_eq("end_err", {31'd0, e}, 32'd1);
    do_acc(1'b1, IO + 32'd8, 32'hBAD0_0008, rd, e, n);
    check_eq("io8_err", {31'd0, e}, 32'd1);
    check_eq("io8_io", io_s, 32'h0000_00A5);
    check_eq("err_idle", {31'd0, err_s}, 32'd0);
    do_acc(1'b0, 32'h10, 32'd0, rd, e, n);
    check_eq("keep10", rd, 32'hDEAD_BEEF);
    do_acc(1'b0, 32'h0, 32'd0, rd, e, n);
    check_eq("keep00", rd, 32'h1111_1111);

    // Timer: clear then read as soon as allowed, then wrap.
    do_acc(1'b1, IO + 32'd4, 32'h1234_5678, rd, e, n);
    do_acc(1'b0, IO + 32'd4, 32'd0, rd, e, n);
    check_eq("tmr_rd", rd, 32'd3);
    force u1.timer_r = 32'hFFFF_FFFE;
    #1;
    release u1.timer_r;
    @(posedge clk); #1;
    check_eq("tmr_ff", u1.timer_r, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check_eq("tmr_wrap", u1.timer_r, 32'd0);

    // Zero wait states: back-to-back loads, one ready every 3 cycles.
    sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      do_acc(1'b1, 32'(i * 4), 32'hA0 + 32'(i), rd, e, n);
      check_eq("ws0_st_lat", 32'(n), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      do_acc(1'b0, 32'(i * 4), 32'd0, rd, e, n);
      check_eq("ws0_ld_rd", rd, 32'hA0 + 32'(i));
      if (i > 0) check_eq("ws0_period", 32'(rdy_cyc - prev_cyc), 32'd3);
      prev_cyc = rdy_cyc;
    end

    // Three wait states, then reset in the middle of a store.
    sel = 2'd2;
    do_acc(1'b1, 32'h20, 32'hCAFE_0020, rd, e, n);
    check_eq("ws3_lat", 32'(n), 32'd6);
    do_acc(1'b1, 32'h14, 32'h1414_1414, rd, e, n);
    do_acc(1'b1, IO, 32'h0000_003C, rd, e, n);
    do_acc(1'b0, 32'h14, 32'd0, rd, e, n);
    check_eq("ws3_ld14", rd, 32'h1414_1414);
    we = 1'b1; addr = 32'h20; wdata = 32'hBBBB_BBBB; req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    req = 1'b0;
    check_eq("mid_ready", {31'd0, rdy_s}, 32'd0);
    check_eq("mid_rdata", rdata_s, 32'd0);
    check_eq("mid_io", io_s, 32'd0);
    check_eq("mid_timer", u3.timer_r, 32'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy_s) pulses++;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rdy_s) pulses++;
    end
    check_eq("mid_pulses", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    do_acc(1'b0, 32'h20, 32'd0, rd, e, n);
    check_eq("mid_keep20", rd, 32'hCAFE_0020);
    check_eq("mid_lat", 32'(n), 32'd6);
    do_acc(1'b0, 32'h14, 32'd0, rd, e, n);
    check_eq("ram_noreset", rd, 32'h1414_1414);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
